ccff_bitstream_loader: RTL and testbench

- Drives the configuration-chain head (ccff_head) of a tile column/row and receives the old chain contents from ccff_tail.
- Accepts bitstream words over a valid/ready stream, serializes them LSB-first, and asserts a shift enable. The chain clock gate uses that enable so the chain's flops advance only on shift cycles.
- Packs the bits shifted out of ccff_tail into readback words for bitstream verification.

---
 rtl/ccff_loader_pkg.sv | 16 +
 rtl/ccff_readback_packer.sv | 56 +++++
 rtl/ccff_bitstream_loader.sv | 162 ++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2,
    DONE = 2'd3
  } state_e;

  // Number of bitstream words consumed by one full chain load.
  function automatic int words_per_load(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage : ccff_loader_pkg

// File: rtl/ccff_readback_packer.sv
// Collects the bits leaving the configuration chain tail into readback words.
// Bit 0 of each word is the first bit shifted out. A flush on the final shift
// emits the partial word zero-padded in its upper bits.
module ccff_readback_packer #(
  parameter int WORD_W = 32
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              shift_en,
  input  logic              tail_bit,
  input  logic              flush,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int RB_CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [RB_CNT_W-1:0] RB_LAST = RB_CNT_W'(WORD_W - 1);
  localparam logic [RB_CNT_W-1:0] RB_ONE  = RB_CNT_W'(1);

  logic [WORD_W-1:0]   pack;
  logic [WORD_W-1:0]   pack_next;
  logic [RB_CNT_W-1:0] rb_cnt;

  // Pack register with the current tail bit merged at position rb_cnt.
  always_comb begin
    // NOTE: assign a default first so every path writes the variable and no latch is inferred.
    pack_next         = pack;
    pack_next[rb_cnt] = tail_bit;
  end

  // Accumulate tail bits; emit a word when full or when the load ends.
  always_ff @(posedge prog_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (pReset) begin
      // NOTE: the pack register is reset, not just the valid flag, so a partial word from an aborted load never leaks into the next one.
      pack     <= '0;
      rb_cnt   <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (shift_en) begin
        if (rb_cnt == RB_LAST || flush) begin
          rb_data  <= pack_next;
          rb_valid <= 1'b1;
          pack     <= '0;
          rb_cnt   <= '0;
        end else begin
          pack   <= pack_next;
          rb_cnt <= rb_cnt + RB_ONE;
        end
      end
    end
  end

endmodule : ccff_readback_packer

// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: accepts bitstream words on a valid/ready stream,
// serialises them LSB-first onto ccff_head with a registered shift enable, and
// packs the old chain contents leaving ccff_tail into readback words.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 48,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int N_WORDS = words_per_load(CHAIN_LEN, WORD_W);
  localparam int WBC_W   = $clog2(WORD_W + 1);
  localparam int WC_W    = $clog2(N_WORDS + 1);

  localparam logic [CNT_W-1:0] CHAIN_END = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [WBC_W-1:0] WORD_END  = WBC_W'(WORD_W);
  localparam logic [WBC_W-1:0] WBC_ONE   = WBC_W'(1);
  localparam logic [WC_W-1:0]  WC_END    = WC_W'(N_WORDS);
  localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);

  state_e            state;
  logic [WORD_W-1:0] sreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WBC_W-1:0]  word_bit_cnt;
  logic [WC_W-1:0]   word_cnt;

  logic             accept;
  logic             chain_full;
  logic             word_empty;
  logic             last_shift;
  logic [CNT_W-1:0] bit_cnt_inc;
  logic [WC_W-1:0]  word_cnt_inc;
  logic             fresh_ready;
  logic             cont_ready;

  // Handshake, end-of-word/end-of-chain detection and look-ahead for bs_ready.
  always_comb begin
    accept       = bs_valid && bs_ready;
    chain_full   = (bit_cnt == CHAIN_END);
    word_empty   = (word_bit_cnt == WORD_END);
    last_shift   = (state == LOAD) && chain_full;
    bit_cnt_inc  = chain_full ? bit_cnt : bit_cnt + CNT_ONE;
    word_cnt_inc = (word_cnt == WC_END) ? word_cnt : word_cnt + WC_ONE;
    // Ready is raised while the last bit of a word is on the head, unless
    // that bit also completes the chain.
    fresh_ready  = (WBC_ONE == WORD_END) && (bit_cnt_inc != CHAIN_END)
                   && (word_cnt_inc < WC_END);
    cont_ready   = ((word_bit_cnt + WBC_ONE) == WORD_END) && (bit_cnt_inc != CHAIN_END)
                   && (word_cnt < WC_END);
  end

  // Load FSM: stream handshake, serialiser and registered chain drive.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state         <= IDLE;
      sreg          <= '0;
      bit_cnt       <= '0;
      word_bit_cnt  <= '0;
      word_cnt      <= '0;
      bs_ready      <= 1'b0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= WAIT;
            bs_ready     <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            bit_cnt      <= '0;
            word_bit_cnt <= '0;
            word_cnt     <= '0;
          end
        end

        WAIT: begin
          // Head holds its last value and the chain is frozen until a word arrives.
          if (accept) begin
            state         <= LOAD;
            ccff_head     <= bs_data[0];
            sreg          <= bs_data >> 1;
            ccff_shift_en <= 1'b1;
            bit_cnt       <= bit_cnt_inc;
            word_bit_cnt  <= WBC_ONE;
            word_cnt      <= word_cnt_inc;
            bs_ready      <= fresh_ready;
          end
        end

        LOAD: begin
          if (chain_full) begin
            // The cycle just ending carried the final chain bit.
            state         <= DONE;
            ccff_shift_en <= 1'b0;
            bs_ready      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
          end else if (word_empty) begin
            if (accept) begin
              // Next word was handed over during the last-bit cycle: no bubble.
              ccff_head     <= bs_data[0];
              sreg          <= bs_data >> 1;
              ccff_shift_en <= 1'b1;
              bit_cnt       <= bit_cnt_inc;
              word_bit_cnt  <= WBC_ONE;
              word_cnt      <= word_cnt_inc;
              bs_ready      <= fresh_ready;
            end else begin
              state         <= WAIT;
              ccff_shift_en <= 1'b0;
              bs_ready      <= (word_cnt < WC_END);
            end
          end else begin
            ccff_head     <= sreg[0];
            sreg          <= sreg >> 1;
            ccff_shift_en <= 1'b1;
            bit_cnt       <= bit_cnt_inc;
            word_bit_cnt  <= word_bit_cnt + WBC_ONE;
            bs_ready      <= cont_ready;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The final shift flushes any partial readback word in the cycle done rises.
  ccff_readback_packer #(
    .WORD_W (WORD_W)
  ) u_packer (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .shift_en (ccff_shift_en),
    .tail_bit (ccff_tail),
    .flush    (last_shift),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );

endmodule : ccff_bitstream_loader

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: a 48-bit chain model driven by the
// main instance, plus a CHAIN_LEN=32 instance for the single-word corner case.
module tb_ccff_bitstream_loader;

  localparam int WORD_W    = 32;
  localparam int CHAIN_LEN = 48;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Main instance signals
  logic                 pReset = 1'b1;
  logic                 start = 1'b0;
  logic [WORD_W-1:0]    bs_data = '0;
  logic                 bs_valid = 1'b0;
  logic                 bs_ready;
  logic                 ccff_head;
  logic                 ccff_shift_en;
  logic                 ccff_tail;
  logic [WORD_W-1:0]    rb_data;
  logic                 rb_valid;
  logic                 busy;
  logic                 done;

  // Single-word instance signals
  logic                 start32 = 1'b0;
  logic [WORD_W-1:0]    bs_data32 = '0;
  logic                 bs_valid32 = 1'b0;
  logic                 bs_ready32;
  logic                 head32;
  logic                 shift32;
  logic                 tail32 = 1'b1;
  logic [WORD_W-1:0]    rb_data32;
  logic                 rb_valid32;
  logic                 busy32;
  logic                 done32;

  ccff_bitstream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .bs_data       (bs_data),
    .bs_valid      (bs_valid),
    .bs_ready      (bs_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid),
    .busy          (busy),
    .done          (done)
  );

  ccff_bitstream_loader #(.WORD_W(WORD_W), .CHAIN_LEN(32)) dut32 (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start32),
    .bs_data       (bs_data32),
    .bs_valid      (bs_valid32),
    .bs_ready      (bs_ready32),
    .ccff_head     (head32),
    .ccff_shift_en (shift32),
    .ccff_tail     (tail32),
    .rb_data       (rb_data32),
    .rb_valid      (rb_valid32),
    .busy          (busy32),
    .done          (done32)
  );

  // Behavioural configuration chain: head enters at the top, tail leaves bit 0.
  logic [CHAIN_LEN-1:0] chain;
  logic                 preload_en = 1'b0;
  logic [CHAIN_LEN-1:0] preload_val = '0;

  always @(posedge prog_clk) begin
    if (preload_en)         chain <= preload_val;
    else if (ccff_shift_en) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
  end
  assign ccff_tail = chain[0];

  // Passive monitor sampled mid-cycle.
  int                shift_total = 0;
  int                run_len = 0;
  int                rb_n = 0;
  int                done_rises = 0;
  int                rise_run = 0;
  logic              prev_shift = 1'b0;
  logic              prev_done = 1'b0;
  logic              rise_prev_shift = 1'b0;
  logic              rise_rb = 1'b0;
  logic [WORD_W-1:0] rb_log [0:15];

  always @(negedge prog_clk) begin
    prev_shift <= ccff_shift_en;
    prev_done  <= done;
    if (ccff_shift_en) begin
      shift_total <= shift_total + 1;
      run_len     <= run_len + 1;
    end else begin
      run_len <= 0;
    end
    if (rb_valid && rb_n < 16) begin
      rb_log[rb_n] <= rb_data;
      rb_n         <= rb_n + 1;
    end
    if (done && !prev_done) begin
      done_rises      <= done_rises + 1;
      rise_prev_shift <= prev_shift;
      rise_rb         <= rb_valid;
      rise_run        <= run_len;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Wait (bounded) until a handshake is presented, then let it be taken.
  task automatic wait_hs(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bs_ready && bs_valid) begin
        got = 1'b1;
        @(negedge prog_clk);
        break;
      end
      @(negedge prog_clk);
    end
  endtask

  task automatic wait_stalled(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bs_ready && !ccff_shift_en) begin
        got = 1'b1;
        break;
      end
      @(negedge prog_clk);
    end
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge prog_clk);
    end
  endtask

  typedef struct packed {
    logic [CHAIN_LEN-1:0] preload;
    logic [WORD_W-1:0]    w0;
    logic [WORD_W-1:0]    w1;
    logic [7:0]           stall;
    logic                 poke_start;
    logic [CHAIN_LEN-1:0] exp_chain;
    logic [WORD_W-1:0]    exp_rb0;
    logic [WORD_W-1:0]    exp_rb1;
  } vec_t;

  vec_t vecs [4];

  task automatic run_load(input vec_t v, input string tag, input bit from_done);
    int   base_shift;
    int   base_rb;
    bit   got;
    bit   stall_ok;
    logic held;

    @(negedge prog_clk);
    preload_val = v.preload;
    preload_en  = 1'b1;
    @(negedge prog_clk);
    preload_en  = 1'b0;
    if (from_done) begin
      check({tag, " done held"}, 64'(done), 64'd1);
      check({tag, " no shift in DONE"}, 64'(ccff_shift_en), 64'd0);
    end
    base_shift = shift_total;
    base_rb    = rb_n;

    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    check({tag, " ready/busy/done after start"}, 64'({bs_ready, busy, done}), 64'b110);

    bs_data  = v.w0;
    bs_valid = 1'b1;
    wait_hs(got);
    check({tag, " word0 accepted"}, 64'(got), 64'd1);
    bs_data = v.w1;
    if (v.poke_start) begin
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
    end
    if (v.stall != 0) begin
      bs_valid = 1'b0;
      wait_stalled(got);
      check({tag, " reached stall"}, 64'(got), 64'd1);
      held     = ccff_head;
      stall_ok = 1'b1;
      for (int i = 0; i < int'(v.stall); i++) begin
        if (ccff_shift_en !== 1'b0 || ccff_head !== held || bs_ready !== 1'b1) stall_ok = 1'b0;
        @(negedge prog_clk);
      end
      check({tag, " chain frozen during stall"}, 64'(stall_ok), 64'd1);
      bs_valid = 1'b1;
    end
    wait_hs(got);
    check({tag, " word1 accepted"}, 64'(got), 64'd1);
    bs_valid = 1'b0;
    bs_data  = '0;
    wait_done(got);
    check({tag, " done reached"}, 64'(got), 64'd1);
    @(negedge prog_clk);
    @(negedge prog_clk);

    check({tag, " shift cycles"}, 64'(shift_total - base_shift), 64'(CHAIN_LEN));
    check({tag, " readback count"}, 64'(rb_n - base_rb), 64'd2);
    check({tag, " rb word 0"}, 64'(rb_log[base_rb]), 64'(v.exp_rb0));
    check({tag, " rb word 1"}, 64'(rb_log[base_rb + 1]), 64'(v.exp_rb1));
    check({tag, " chain contents"}, 64'(chain), 64'(v.exp_chain));
    check({tag, " done follows last shift, rb flushed"},
          64'({rise_prev_shift, rise_rb}), 64'b11);
    if (v.stall == 0) check({tag, " contiguous shift run"}, 64'(rise_run), 64'(CHAIN_LEN));
  endtask

  initial begin
    bit got;
    int n;
    int hs32;
    int sh32;
    int bad32;
    int rbn32;
    logic [WORD_W-1:0] rbd32;

    vecs[0] = '{preload: 48'hC0DE_F00D_CAFE, w0: 32'hA5A5_1234, w1: 32'hFFFF_BEEF,
                stall: 8'd0, poke_start: 1'b0, exp_chain: 48'hBEEF_A5A5_1234,
                exp_rb0: 32'hF00D_CAFE, exp_rb1: 32'h0000_C0DE};
    vecs[1] = '{preload: 48'hC0DE_F00D_CAFE, w0: 32'hA5A5_1234, w1: 32'hFFFF_BEEF,
                stall: 8'd5, poke_start: 1'b0, exp_chain: 48'hBEEF_A5A5_1234,
                exp_rb0: 32'hF00D_CAFE, exp_rb1: 32'h0000_C0DE};
    vecs[2] = '{preload: 48'h1234_5678_9ABC, w0: 32'hDEAD_BEEF, w1: 32'h0000_5555,
                stall: 8'd0, poke_start: 1'b1, exp_chain: 48'h5555_DEAD_BEEF,
                exp_rb0: 32'h5678_9ABC, exp_rb1: 32'h0000_1234};
    vecs[3] = '{preload: 48'hFFFF_FFFF_FFFF, w0: 32'h0000_0000, w1: 32'hFFFF_0000,
                stall: 8'd2, poke_start: 1'b0, exp_chain: 48'h0000_0000_0000,
                exp_rb0: 32'hFFFF_FFFF, exp_rb1: 32'h0000_FFFF};

    // Reset state
    repeat (3) @(negedge prog_clk);
    check("reset outputs", 64'({bs_ready, ccff_head, ccff_shift_en, rb_valid, busy, done}), 64'd0);
    check("reset rb_data", 64'(rb_data), 64'd0);
    pReset = 1'b0;
    @(negedge prog_clk);
    check("idle without start", 64'({bs_ready, busy, done}), 64'd0);

    for (int i = 0; i < 4; i++) begin
      run_load(vecs[i], $sformatf("vec%0d", i), i != 0);
    end

    // Reset in the middle of a load
    start = 1'b1;
    @(negedge prog_clk);
    start    = 1'b0;
    bs_data  = 32'hFFFF_FFFF;
    bs_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge prog_clk);
      if (ccff_shift_en) n++;
      if (n == 20) break;
    end
    check("20 shifts before reset", 64'(n), 64'd20);
    pReset = 1'b1;
    @(negedge prog_clk);
    check("mid-load reset outputs",
          64'({bs_ready, ccff_shift_en, rb_valid, busy, done}), 64'd0);
    check("mid-load reset rb_data", 64'(rb_data), 64'd0);
    pReset   = 1'b0;
    bs_valid = 1'b0;
    run_load(vecs[0], "after reset", 1'b0);

    // Single-word chain: one handshake, no ready during the final-bit cycle
    @(negedge prog_clk);
    start32 = 1'b1;
    @(negedge prog_clk);
    start32    = 1'b0;
    bs_data32  = 32'h1357_9BDF;
    bs_valid32 = 1'b1;
    hs32  = 0;
    sh32  = 0;
    bad32 = 0;
    rbn32 = 0;
    rbd32 = '0;
    for (int i = 0; i < 100 && !done32; i++) begin
      if (bs_ready32 && bs_valid32) hs32++;
      if (shift32) sh32++;
      if (bs_ready32 && shift32) bad32++;
      if (rb_valid32) begin
        rbn32++;
        rbd32 = rb_data32;
      end
      @(negedge prog_clk);
      if (hs32 == 1) bs_data32 = 32'h2468_ACE0;
    end
    if (rb_valid32) begin
      rbn32++;
      rbd32 = rb_data32;
    end
    check("len32 done", 64'(done32), 64'd1);
    check("len32 words consumed", 64'(hs32), 64'd1);
    check("len32 shift cycles", 64'(sh32), 64'd32);
    check("len32 ready during shift", 64'(bad32), 64'd0);
    check("len32 readback", 64'({rbn32[7:0], rbd32}), {24'd0, 8'd1, 32'hFFFF_FFFF});
    repeat (3) @(negedge prog_clk);
    check("len32 no ready in DONE", 64'({bs_ready32, shift32, done32}), 64'b001);
    bs_valid32 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_ccff_bitstream_loader
